scpad_bank_rsp: RTL

SRAM-side responder for one scratchpad bank. It accepts the write and read requests that the per-bank scratchpad controller drains from its request FIFOs and issues at most one access per cycle to a fixed-latency SRAM bank. Read data and tags are returned in order through a credit-protected response FIFO. A busy indication is exported to the controller to throttle draining.

---
 rtl/scpad_bank_rsp.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/scpad_bank_rsp.sv
// Scratchpad bank responder: arbitrates write/read requests onto one SRAM port, returns read data in order.
// Latency: read accept -> rsp_valid after SRAM_LAT+1 cycles; write accept -> wr_ack pulse 1 cycle later.
// Backpressure: reads stall when in-flight + queued responses reach RSP_DEPTH (busy); writes never stall except by arbitration.

// Small synchronous FIFO used for the response queue; head entry is read straight from storage registers.
module scpad_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // Storage and pointers; reset clears storage so the head reads as zero after a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= ptr_inc(wptr);
      end
      if (do_pop) begin
        rptr <= ptr_inc(rptr);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Credit accounting upstream must make a push into a full queue impossible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      no_overflow: assert (!(push && full));
    end
  end

endmodule

// Bank responder top: one SRAM access per cycle, in-order read responses under read credit.
module scpad_bank_rsp #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 128,
  parameter int TAG_W     = 4,
  parameter int SRAM_LAT  = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_mask,
  output logic                  wr_ack,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic [TAG_W-1:0]      rd_tag,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  output logic [DATA_W/8-1:0]   sram_wmask,
  input  logic [DATA_W-1:0]     sram_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic                  busy
);

  localparam int UW = $clog2(RSP_DEPTH + 1);
  localparam int EW = DATA_W + TAG_W;

  // used counts reads in the SRAM pipeline plus responses waiting in the queue.
  logic [UW-1:0]    used;
  logic             credit_ok;
  logic             prio;
  logic             wr_elig;
  logic             rd_elig;
  logic             wr_win;
  logic             rd_win;
  logic             wr_go;
  logic             rd_go;
  logic             rsp_pop;
  logic             fifo_push;
  logic             fifo_empty;
  logic             fifo_full;
  logic [EW-1:0]    fifo_din;
  logic [EW-1:0]    fifo_head;

  logic [SRAM_LAT-1:0] pipe_vld;
  logic [TAG_W-1:0]    pipe_tag [SRAM_LAT];

  assign credit_ok = (used < UW'(RSP_DEPTH));
  assign busy      = !credit_ok;

  // Arbitration: a lone eligible channel wins; under contention prio picks (0 = write, 1 = read).
  assign wr_elig = wr_valid;
  assign rd_elig = rd_valid && credit_ok;
  assign wr_win  = wr_elig && (!rd_elig || !prio);
  assign rd_win  = rd_elig && (!wr_elig || prio);

  assign wr_ready = !rst && wr_win;
  assign rd_ready = !rst && rd_win;
  assign wr_go    = wr_valid && wr_ready;
  assign rd_go    = rd_valid && rd_ready;

  // SRAM port is driven straight from the grant; idle cycles present zero write data and mask.
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wmask = '0;
    if (wr_go) begin
      sram_en    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = wr_addr;
      sram_wdata = wr_data;
      sram_wmask = wr_mask;
    end else if (rd_go) begin
      sram_en   = 1'b1;
      sram_addr = rd_addr;
    end
  end

  // Flip priority after every contended grant so contended traffic alternates.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (wr_elig && rd_elig) begin
      prio <= !prio;
    end
  end

  // One-cycle acknowledge for every accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= wr_go;
    end
  end

  // Valid bits track reads through the SRAM latency; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= rd_go;
      for (int i = 1; i < SRAM_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  // Tags ride alongside the valid bits; they only matter where the valid bit is set.
  always_ff @(posedge clk) begin
    pipe_tag[0] <= rd_tag;
    for (int i = 1; i < SRAM_LAT; i++) begin
      pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  assign fifo_push = pipe_vld[SRAM_LAT-1];
  assign fifo_din  = {sram_rdata, pipe_tag[SRAM_LAT-1]};
  assign rsp_pop   = rsp_valid && rsp_ready;

  // Read credit: +1 on accept, -1 on response pop, net zero when both happen together.
  always_ff @(posedge clk) begin
    if (rst) begin
      used <= '0;
    end else begin
      case ({rd_go, rsp_pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: ;
      endcase
    end
  end

  scpad_fifo #(
    .W     (EW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (rsp_pop),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rsp_valid           = !fifo_empty;
  assign {rsp_data, rsp_tag} = fifo_head;

  // Queue fullness is implied by the credit counter; kept visible for debug only.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule
